// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding, opcodes,
// ALU operation codes and the per-state control decode used by the FSM.
package unidade_controle_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'b0000,
    DECODE    = 4'b0001,
    EXEC_R    = 4'b0010,
    EXEC_I    = 4'b0011,
    MEM_ADDR  = 4'b0100,
    MEM_READ  = 4'b0101,
    MEM_WRITE = 4'b0110,
    WRITEBACK = 4'b0111,
    BRANCH    = 4'b1000,
    HALT      = 4'b1111
  } estado_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    FMT_I = 2'd0,
    FMT_S = 2'd1,
    FMT_B = 2'd2
  } formato_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
  } controle_t;

  // Only the instruction fields the control path needs after DECODE.
  typedef struct packed {
    logic [11:0] alto;    // instr[31:20]
    logic [4:0]  baixo;   // instr[11:7]
    logic [6:0]  opcode;  // instr[6:0]
  } campos_t;

  function automatic controle_t controles(estado_t s, logic [6:0] opcode);
    controle_t c;
    c = '0;
    case (s)
      EXEC_R:    c.alu_op = ALU_FUNCT;
      EXEC_I:    begin c.alu_op = ALU_FUNCT; c.alu_src = 1'b1; end
      MEM_ADDR:  begin c.alu_op = ALU_ADD;   c.alu_src = 1'b1; end
      MEM_READ:  c.mem_read = 1'b1;
      MEM_WRITE: c.mem_write = 1'b1;
      WRITEBACK: begin c.reg_write = 1'b1; c.mem_to_reg = (opcode == OP_LOAD); end
      BRANCH:    c.alu_op = ALU_SUB;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_gerador_imediato.sv
// Combinational immediate generator for I, S and B instruction formats,
// fed only with the instruction fields that carry immediate bits.
module gerador_imediato
  import unidade_controle_pkg::*;
(
  input  logic [11:0]        alto,
  input  logic [4:0]         baixo,
  input  formato_t           formato,
  output logic signed [31:0] imediato
);

  // NOTE: assign a default before the case so no path leaves imediato unassigned (no latch).
  always_comb begin
    imediato = '0;
    case (formato)
      FMT_I:   imediato = {{20{alto[11]}}, alto};
      FMT_S:   imediato = {{20{alto[11]}}, alto[11:5], baixo};
      FMT_B:   imediato = {{19{alto[11]}}, alto[11], baixo[0], alto[10:5], baixo[4:1], 1'b0};
      default: imediato = '0;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM: fetch/decode/execute sequencing, word-indexed pc,
// branch redirection and registered Moore datapath controls.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int unsigned N_INSTR = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] instrucao,
  input  logic        zero,
  output logic [3:0]  estado,
  output logic [31:0] pc,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        halt,
  output logic        err
);

  estado_t            state;
  logic [31:0]        pc_atual;
  campos_t            campos;
  controle_t          ctrl;
  formato_t           formato;
  logic signed [31:0] imediato;
  logic [31:0]        desloc;

  always_comb begin
    formato = FMT_I;
    if (campos.opcode == OP_STORE)  formato = FMT_S;
    if (campos.opcode == OP_BRANCH) formato = FMT_B;
  end

  gerador_imediato u_imm (
    .alto     (campos.alto),
    .baixo    (campos.baixo),
    .formato  (formato),
    .imediato (imediato)
  );

  // pc counts words, so the byte offset of a branch is scaled down by 4.
  assign desloc = 32'(imediato >>> 2);

  // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= '0;
      pc_atual <= '0;
      campos   <= '0;
      ctrl     <= '0;
      halt     <= 1'b0;
      err      <= 1'b0;
    end else if (en) begin
      case (state)
        FETCH: begin
          ctrl <= '0;
          if (pc >= N_INSTR) begin
            state <= HALT;
            halt  <= 1'b1;
          end else begin
            state    <= DECODE;
            pc_atual <= pc;
            pc       <= pc + 32'd1;
          end
        end
        DECODE: begin
          campos <= '{alto: instrucao[31:20], baixo: instrucao[11:7], opcode: instrucao[6:0]};
          if (instrucao == '0) begin
            state <= HALT;
            halt  <= 1'b1;
            ctrl  <= '0;
          end else begin
            case (instrucao[6:0])
              OP_R:      begin state <= EXEC_R;   ctrl <= controles(EXEC_R, instrucao[6:0]); end
              OP_I:      begin state <= EXEC_I;   ctrl <= controles(EXEC_I, instrucao[6:0]); end
              OP_LOAD,
              OP_STORE:  begin state <= MEM_ADDR; ctrl <= controles(MEM_ADDR, instrucao[6:0]); end
              OP_BRANCH: begin state <= BRANCH;   ctrl <= controles(BRANCH, instrucao[6:0]); end
              default: begin
                state <= HALT;
                halt  <= 1'b1;
                err   <= 1'b1;
                ctrl  <= '0;
              end
            endcase
          end
        end
        EXEC_R, EXEC_I, MEM_READ: begin
          state <= WRITEBACK;
          ctrl  <= controles(WRITEBACK, campos.opcode);
        end
        MEM_ADDR: begin
          if (campos.opcode == OP_LOAD) begin
            state <= MEM_READ;
            ctrl  <= controles(MEM_READ, campos.opcode);
          end else begin
            state <= MEM_WRITE;
            ctrl  <= controles(MEM_WRITE, campos.opcode);
          end
        end
        MEM_WRITE, WRITEBACK: begin
          state <= FETCH;
          ctrl  <= '0;
        end
        BRANCH: begin
          if (zero) pc <= pc_atual + desloc;
          state <= FETCH;
          ctrl  <= '0;
        end
        HALT: state <= HALT;
        default: begin
          state <= HALT;
          halt  <= 1'b1;
          ctrl  <= '0;
        end
      endcase
    end
  end

  assign estado     = state;
  assign reg_write  = ctrl.reg_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src    = ctrl.alu_src;
  assign alu_op     = ctrl.alu_op;

endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter N_INSTR, default 9: number of instruction-memory words; a fetch at pc >= N_INSTR SHALL halt.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  step enable; the FSM SHALL advance only in cycles where en=1, otherwise all registers hold.
REQ-005 instrucao  input  32  instruction word from the instruction memory, valid from the cycle after estado=FETCH.
REQ-006 zero  input  1  ALU zero flag, sampled in state BRANCH.
REQ-007 estado  output  4  current FSM state, registered; drives the instruction memory's fetch qualifier.
REQ-008 pc  output  32  word index of the next instruction; increments by 1 per instruction, not by 4.
REQ-009 reg_write, mem_read, mem_write, mem_to_reg, alu_src  output  1 each  datapath controls, decoded from estado and opcode.
REQ-010 alu_op  output  2  00 add, 01 subtract/compare, 10 use funct3/funct7.
REQ-011 halt  output  1  high while in HALT; err  output  1  sticky, set on illegal opcode.

Function
REQ-012 State encoding SHALL be FETCH 0000, DECODE 0001, EXEC_R 0010, EXEC_I 0011, MEM_ADDR 0100, MEM_READ 0101, MEM_WRITE 0110, WRITEBACK 0111, BRANCH 1000, HALT 1111.
REQ-013 FETCH -> DECODE unconditionally (when en=1); the instruction memory latches instrucoes[pc] at that edge.
REQ-014 On the FETCH->DECODE edge, pc_atual SHALL capture pc, and pc SHALL become pc+1 (32-bit wrap).
REQ-015 DECODE SHALL dispatch on instrucao[6:0]: 0110011->EXEC_R, 0010011->EXEC_I, 0000011 or 0100011->MEM_ADDR, 1100011->BRANCH; instrucao==0 ->HALT; any other opcode ->HALT with err set.
REQ-016 EXEC_R and EXEC_I -> WRITEBACK; MEM_ADDR -> MEM_READ for opcode 0000011, MEM_WRITE for 0100011; MEM_READ -> WRITEBACK; MEM_WRITE, WRITEBACK, BRANCH -> FETCH.
REQ-017 In BRANCH, if zero=1, pc SHALL become pc_atual + (sign-extended B-immediate arithmetically shifted right by 2); if zero=0, pc is unchanged.
REQ-018 In FETCH, if pc >= N_INSTR, the next state SHALL be HALT instead of DECODE and pc SHALL not increment.
REQ-019 HALT SHALL be absorbing; only rst leaves it.
REQ-020 Controls (Moore, from registered state plus opcode): EXEC_R alu_op=10 alu_src=0; EXEC_I alu_op=10 alu_src=1; MEM_ADDR alu_op=00 alu_src=1; BRANCH alu_op=01 alu_src=0; MEM_READ mem_read=1; MEM_WRITE mem_write=1; WRITEBACK reg_write=1, mem_to_reg=1 only when the opcode is load; all others 0.
REQ-021 en=0 in any state SHALL freeze estado, pc, pc_atual and hold the control outputs steady.

Reset
REQ-022 rst=1 SHALL immediately force estado=FETCH, pc=0, pc_atual=0, err=0, halt=0 and all controls 0, regardless of clk or en.
REQ-023 rst asserted mid-instruction SHALL abandon it; no mem_write or reg_write pulse occurs after the rst edge.
REQ-024 The first fetch after deassertion SHALL read index 0.

Structure
REQ-025 State encodings, opcode constants and alu_op codes SHALL live in a shared package/header used by datapath and memory blocks.
REQ-026 Immediate extraction SHALL be a sub-module gerador_imediato (combinational, I/S/B formats); the remainder is a single FSM module.

Verification
REQ-027 rst pulse mid-MEM_WRITE -> estado=0000, pc=0, mem_write=0 immediately without waiting for clk.
REQ-028 R-type 0x405282B3, en=1 -> states 0000,0001,0010,0111,0000; reg_write=1 for exactly one cycle; pc 0->1.
REQ-029 lw 0x0000A003 -> 0000,0001,0100,0101,0111; mem_read=1 in 0101; mem_to_reg=1 in 0111; sw 0x00219223 -> ends in 0110 with mem_write=1.
REQ-030 beq 0x00000463 at pc=6, zero=1 -> pc=6+2=8; zero=0 -> pc=7.
REQ-031 instrucao=0 -> HALT, halt=1, err=0; opcode 1111111 -> HALT, err=1; N_INSTR=9 with pc reaching 9 -> HALT from FETCH.
REQ-032 en held 0 for 5 cycles in EXEC_I -> estado, pc and controls unchanged; resumes on en=1.
